generador_obstaculos_multi: RTL

//  Parametrised successor obstacle generator for the game core.

---
 rtl/generador_obstaculos_multi.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/generador_obstaculos_multi.sv
// Multi-world obstacle generator: tick-enable divider, LFSR obstacle types,
// shifting multi-lane display with a bonus slot closing each world.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for the first tick of a game
// S_CARGA  | one cycle: load world length, LFSR from seed, clear phase
// S_EMITE  | ticks alternate obstacle / gap, LFSR steps on gap ticks
// S_BONO   | next tick injects the bonus marker
// S_ESPERA | slots drain until bono_tomado advances the world
// S_FIN    | last world done; no injection until presente leaves the game
module generador_obstaculos_multi #(
   parameter int                LANES       = 3,
   parameter int                SEG_W       = 7,
   parameter int                LFSR_W      = 4,
   parameter logic [LFSR_W-1:0] TAPS        = 4'b0011,
   parameter int                NUM_MUNDOS  = 3,
   parameter int                CONTEO_BASE = 15,
   parameter int                CONTEO_INC  = 5,
   parameter int                DIV_BASE    = 18000000,
   parameter int                DIV_STEP    = 2700000,
   parameter logic [2:0]        GAME        = 3'd3,
   parameter logic [2:0]        WL          = 3'd4,
   parameter logic [2:0]        PA          = 3'd5,
   localparam int               MUNDO_W     = $clog2(NUM_MUNDOS + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [2:0]               presente,
   input  logic [1:0]               W_or_L,
   input  logic                     bono_tomado,
   input  logic [SEG_W-1:0]         obstaculo,
   output logic                     tick_obs,
   output logic [MUNDO_W-1:0]       mundo,
   output logic [LFSR_W:0]          tipo_obs,
   output logic [LANES*SEG_W-1:0]   display_obs,
   output logic                     juego_fin
);

   localparam int DIV_W   = $clog2(DIV_BASE);
   localparam int CNT_MAX = CONTEO_BASE + NUM_MUNDOS * CONTEO_INC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [LFSR_W:0] TIPO_BONO = {1'b1, {LFSR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_CARGA, S_EMITE, S_BONO, S_ESPERA, S_FIN
   } estado_t;

   estado_t                  state, state_n;
   logic [DIV_W-1:0]         div;
   logic [31:0]              div_lim;
   logic                     jugando, valido;
   logic                     bono_q, bono_edge, mundo_inc, div_clr;
   logic [LFSR_W-1:0]        seed, lfsr, lfsr_n;
   logic [CNT_W-1:0]         conteo, conteo_n, conteo_ini;
   logic                     fase, fase_n;
   logic [LFSR_W:0]          tipo_n;
   logic [LANES*SEG_W-1:0]   display_n;
   logic [SEG_W-1:0]         entry;

   // An all-zero register would never leave zero, so any update landing there reloads 1.
   function automatic logic [LFSR_W-1:0] lfsr_fix(input logic [LFSR_W-1:0] v);
      return (v == '0) ? LFSR_W'(1) : v;
   endfunction

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
      logic fb;
      fb = ^(v & TAPS);
      return {fb, v[LFSR_W-1:1]};
   endfunction

   assign jugando    = (presente == GAME) && (W_or_L == 2'b00);
   assign valido     = presente inside {GAME, WL, PA};
   assign bono_edge  = bono_tomado && !bono_q;
   assign mundo_inc  = bono_edge && ((presente == GAME) || (presente == WL))
                       && (mundo != MUNDO_W'(NUM_MUNDOS));
   assign div_clr    = mundo_inc || (!valido && (mundo != '0));
   assign div_lim    = 32'(DIV_BASE) - 32'(mundo) * 32'(DIV_STEP) - 32'd1;
   assign tick_obs   = rst_n && jugando && (32'(div) == div_lim);
   assign juego_fin  = (mundo == MUNDO_W'(NUM_MUNDOS));
   assign conteo_ini = CNT_W'(CONTEO_BASE + int'(mundo) * CONTEO_INC);

   always_comb begin
      state_n   = state;
      conteo_n  = conteo;
      fase_n    = fase;
      lfsr_n    = lfsr;
      tipo_n    = tipo_obs;
      display_n = display_obs;
      entry     = '0;
      if (!valido) begin
         state_n   = S_IDLE;
         conteo_n  = '0;
         fase_n    = 1'b0;
         tipo_n    = '0;
         display_n = '0;
      end else begin
         case (state)
            S_IDLE:   if (tick_obs) state_n = S_CARGA;
            S_CARGA: begin
               conteo_n = conteo_ini;
               lfsr_n   = lfsr_fix(seed);
               fase_n   = 1'b0;
               state_n  = S_EMITE;
            end
            // The world ends once the count reaches 2; the following tick carries the bonus.
            S_EMITE: begin
               if (conteo <= CNT_W'(2)) begin
                  state_n = S_BONO;
               end else if (tick_obs) begin
                  conteo_n = conteo - CNT_W'(1);
                  fase_n   = !fase;
                  if (!fase) begin
                     entry  = obstaculo;
                     tipo_n = {1'b0, lfsr};
                  end else begin
                     lfsr_n = lfsr_fix(lfsr_next(lfsr));
                  end
               end
            end
            S_BONO: begin
               if (tick_obs) begin
                  entry   = obstaculo;
                  tipo_n  = TIPO_BONO;
                  state_n = S_ESPERA;
               end
            end
            S_ESPERA: begin
               if (mundo_inc)
                  state_n = (mundo == MUNDO_W'(NUM_MUNDOS - 1)) ? S_FIN : S_CARGA;
            end
            S_FIN:    state_n = S_FIN;
            default:  state_n = S_IDLE;
         endcase
         if (tick_obs) display_n = {entry, display_obs[LANES*SEG_W-1:SEG_W]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         div         <= '0;
         seed        <= LFSR_W'(1);
         lfsr        <= LFSR_W'(1);
         bono_q      <= 1'b0;
         mundo       <= '0;
         conteo      <= '0;
         fase        <= 1'b0;
         tipo_obs    <= '0;
         display_obs <= '0;
      end else begin
         state       <= state_n;
         seed        <= (seed == '1) ? LFSR_W'(1) : seed + LFSR_W'(1);
         lfsr        <= lfsr_n;
         bono_q      <= bono_tomado;
         conteo      <= conteo_n;
         fase        <= fase_n;
         tipo_obs    <= tipo_n;
         display_obs <= display_n;

         if (div_clr || tick_obs) div <= '0;
         else if (jugando)        div <= div + DIV_W'(1);

         if (!valido)        mundo <= '0;
         else if (mundo_inc) mundo <= mundo + MUNDO_W'(1);
      end
   end

endmodule
